ex_muldiv_unit: RTL and testbench
=================================

// Module: ex_muldiv_unit
// PURPOSE
//  Parametrised multi-cycle RV32M execute unit sitting beside the single-cycle EX ALU.
//  Accepts MUL/MULH/MULHSU/MULHU/DIV/DIVU/REM/REMU from ID via valid/ready.
//  Pipelined multiplier plus iterative radix-2 restoring divider; writes back via out_* pulse.
//  While busy, the core holds IF/ID.
// PARAMETERS
//  XLEN        32  operand/result width (>=8, even)
//  MUL_STAGES  2   multiplier latency in cycles, 1..4
//  RD_W        5   destination register index width
// PORTS
//  clk        in   1     clock, all state on rising edge
//  rst        in   1     asynchronous active-high reset
//  in_vld     in   1     request valid
//  in_rdy     out  1     unit can accept request (state==IDLE)
//  in_op      in   3     funct3: 0 MUL,1 MULH,2 MULHSU,3 MULHU,4 DIV,5 DIVU,6 REM,7 REMU
//  in_x_rs1   in   XLEN  operand A (dividend)
//  in_x_rs2   in   XLEN  operand B (divisor)
//  in_rd      in   RD_W  destination register
//  flush      in   1     abort in-flight op (branch/trap redirect)
//  busy       out  1     op in flight (state!=IDLE)
//  out_vld    out  1     one-cycle result strobe
//  out_rd     out  RD_W  destination of result
//  out_x_rd   out  XLEN  result value
// BEHAVIOUR
//  Reset: state=IDLE, in_rdy=1, busy=0, out_vld=0, out_rd=0, out_x_rd=0, internal regs 0.
//  Accept = in_vld & in_rdy & ~flush; op/operands/rd captured that edge (cycle 0).
//  FSM: IDLE -accept MUL*-> MUL; IDLE -accept DIV/REM-> DSETUP; MUL -count done-> DONE;
//   DSETUP -> DITER (XLEN cycles) -> DFIX -> DONE; DONE -> IDLE (in_rdy=1 again).
//  out_vld=1 only in DONE for exactly one cycle; out_rd/out_x_rd hold until next result.
//  No back-to-back: next accept earliest the cycle out_vld is high? No: in_rdy=0 in DONE.
//  MUL latency: out_vld in cycle MUL_STAGES+1 after accept.
//  DIV latency: out_vld in cycle XLEN+3 after accept (setup 1, iter XLEN, fix 1, done 1).
//  Multiply: operands extended to 2*XLEN per op (MULHSU: A signed, B unsigned);
//   MUL returns low XLEN bits of product, MULH* return high XLEN bits.
//  Divide: DSETUP takes magnitudes (signed ops); DITER shifts 1 quotient bit/cycle;
//   DFIX negates quotient if signs differ, remainder takes dividend sign.
//  Div by zero: quotient = all ones, remainder = dividend (signed and unsigned).
//  Signed overflow (-2^(XLEN-1) / -1): quotient = dividend, remainder = 0.
//  Special cases are detected in DSETUP and forced in DFIX (no X, no trap).
//  flush: any non-IDLE state -> IDLE next edge, out_vld suppressed, outputs keep old value;
//   flush in DONE cycle still suppresses out_vld. flush with in_vld in IDLE: not accepted.
//  Async rst asserted mid-op: immediate return to reset values, op discarded.
//  rd==0 results still strobed; regfile ignores x0.
// CONFIGURATION
//  MDU_DIV_EARLY_OUT_EN defined: div-by-zero and signed overflow skip DITER/DFIX,
//   DSETUP -> DONE, out_vld in cycle 2 after accept; normal divides unchanged.
//  Undefined: all divides take full XLEN+3 cycles; results identical either way.
// TESTING
//  MULH A=0x80000000,B=0x80000000 -> out_x_rd=0x40000000 at cycle MUL_STAGES+1, one pulse.
//  MULHSU A=0xFFFFFFFF,B=0xFFFFFFFF -> 0xFFFFFFFF; MUL 7*-3 -> 0xFFFFFFEB, rd echoed.
//  DIV -7/2 -> 0xFFFFFFFD; REM -7/2 -> 0xFFFFFFFF; DIVU 100/7 -> 14 at cycle 35.
//  DIV 5/0 -> 0xFFFFFFFF, REM 5/0 -> 5; DIV 0x80000000/-1 -> 0x80000000, REM -> 0;
//   latency 2 with MDU_DIV_EARLY_OUT_EN, 35 without.
//  Start DIVU, assert flush at cycle 10 -> busy=0,in_rdy=1 next cycle, no out_vld ever;
//   new MUL accepted immediately after completes normally.
//  Assert rst at cycle 5 of DIV -> all outputs to reset values same cycle, no strobe.

Source files
------------

// File: rtl/ex_muldiv_unit.sv
// ex_muldiv_unit -- multi-cycle RV32M execute unit (MUL/MULH/MULHSU/MULHU/DIV/DIVU/REM/REMU).
//
// A pipelined multiplier (MUL_STAGES cycles) and an iterative radix-2 restoring
// divider share one valid/ready request port and one result strobe. Only one
// operation is in flight at a time; the core stalls IF/ID while busy is high.
//
// Ports:
//   clk       rising-edge clock
//   rst       asynchronous active-high reset
//   in_vld    request valid            in_rdy   unit idle, can accept
//   in_op     funct3 (0..7, RV32M order)
//   in_x_rs1  operand A / dividend     in_x_rs2 operand B / divisor
//   in_rd     destination register
//   flush     abort any in-flight operation, suppress its result
//   busy      operation in flight
//   out_vld   one-cycle result strobe
//   out_rd    destination of the result (holds until next result)
//   out_x_rd  result value (holds until next result)
//
// Configuration macro: MDU_DIV_EARLY_OUT_EN -- when defined, divide-by-zero and
// signed overflow complete directly from setup (result two cycles after accept).

module ex_muldiv_unit #(
    parameter int XLEN       = 32,
    parameter int MUL_STAGES = 2,
    parameter int RD_W       = 5
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            in_vld,
    output logic            in_rdy,
    input  logic [2:0]      in_op,
    input  logic [XLEN-1:0] in_x_rs1,
    input  logic [XLEN-1:0] in_x_rs2,
    input  logic [RD_W-1:0] in_rd,
    input  logic            flush,
    output logic            busy,
    output logic            out_vld,
    output logic [RD_W-1:0] out_rd,
    output logic [XLEN-1:0] out_x_rd
);

    localparam int CNT_W = $clog2(XLEN + 1);

    localparam logic [2:0] OP_MULH   = 3'd1;
    localparam logic [2:0] OP_MULHSU = 3'd2;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_MUL    = 3'd1,
        S_DSETUP = 3'd2,
        S_DITER  = 3'd3,
        S_DFIX   = 3'd4,
        S_DONE   = 3'd5
    } state_t;

    state_t            state_r, state_nxt_s;
    logic [2:0]        op_r;
    logic [XLEN-1:0]   a_r, b_r;
    logic [RD_W-1:0]   rd_r;
    logic [CNT_W-1:0]  cnt_r;
    logic [XLEN-1:0]   dvd_r, dvs_r, rem_r;
    logic              div0_r, ovf_r, neg_q_r, neg_r_r;
    logic [XLEN-1:0]   res_r, out_x_hold_r;
    logic [RD_W-1:0]   out_rd_hold_r;

    logic              accept_s;
    logic [2*XLEN-1:0] a_ext_s, b_ext_s, prod_s, mul_tail_s;
    logic [XLEN-1:0]   mul_res_s, fix_res_s, res_nxt_s;
    logic              load_res_s;
    logic              div_sgn_s, div0_s, ovf_s;
    logic [XLEN-1:0]   abs_a_s, abs_b_s;
    logic [XLEN:0]     trial_s, diff_s;
    logic              q_bit_s;

    // Forced result for divide-by-zero (by_zero=1) or signed overflow (by_zero=0).
    function automatic logic [XLEN-1:0] special_result(input logic is_rem,
                                                       input logic by_zero,
                                                       input logic [XLEN-1:0] dividend);
        if (by_zero) begin
            return is_rem ? dividend : {XLEN{1'b1}};
        end else begin
            return is_rem ? {XLEN{1'b0}} : dividend;
        end
    endfunction

    assign accept_s = in_vld & (state_r == S_IDLE) & ~flush;

    // Operand extension for the multiplier: MULHSU treats only A as signed.
    always_comb begin
        a_ext_s = {{XLEN{1'b0}}, a_r};
        b_ext_s = {{XLEN{1'b0}}, b_r};
        if (op_r == OP_MULH || op_r == OP_MULHSU) begin
            a_ext_s = {{XLEN{a_r[XLEN-1]}}, a_r};
        end else begin
            a_ext_s = {{XLEN{1'b0}}, a_r};
        end
        if (op_r == OP_MULH) begin
            b_ext_s = {{XLEN{b_r[XLEN-1]}}, b_r};
        end else begin
            b_ext_s = {{XLEN{1'b0}}, b_r};
        end
    end

    assign prod_s = a_ext_s * b_ext_s;

    // Extra product register stages beyond the one folded into res_r.
    generate
        if (MUL_STAGES == 1) begin : g_mul_comb
            assign mul_tail_s = prod_s;
        end else begin : g_mul_pipe
            logic [2*XLEN-1:0] pipe_r [MUL_STAGES-1];

            // Product pipeline shift register.
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    for (int i = 0; i < MUL_STAGES - 1; i++) pipe_r[i] <= {2*XLEN{1'b0}};
                end else begin
                    pipe_r[0] <= prod_s;
                    for (int i = 1; i < MUL_STAGES - 1; i++) pipe_r[i] <= pipe_r[i-1];
                end
            end

            assign mul_tail_s = pipe_r[MUL_STAGES-2];
        end
    endgenerate

    // MUL returns the low half, every MULH* variant the high half.
    assign mul_res_s = (op_r[1:0] == 2'b00) ? mul_tail_s[XLEN-1:0] : mul_tail_s[2*XLEN-1:XLEN];

    // Divider: op_r[0]=1 unsigned, op_r[1]=1 remainder.
    assign div_sgn_s = ~op_r[0];
    assign div0_s    = (b_r == {XLEN{1'b0}});
    assign ovf_s     = div_sgn_s & (a_r == {1'b1, {(XLEN-1){1'b0}}}) & (b_r == {XLEN{1'b1}});
    assign abs_a_s   = (div_sgn_s & a_r[XLEN-1]) ? -a_r : a_r;
    assign abs_b_s   = (div_sgn_s & b_r[XLEN-1]) ? -b_r : b_r;

    // Restoring step: shift in the next dividend bit, subtract if it fits.
    assign trial_s = {rem_r, dvd_r[XLEN-1]};
    assign diff_s  = trial_s - {1'b0, dvs_r};
    assign q_bit_s = ~diff_s[XLEN];

    // Sign fix-up and special-case override applied after the last iteration.
    always_comb begin
        fix_res_s = dvd_r;
        if (div0_r | ovf_r) begin
            fix_res_s = special_result(op_r[1], div0_r, a_r);
        end else if (op_r[1]) begin
            fix_res_s = neg_r_r ? -rem_r : rem_r;
        end else begin
            fix_res_s = neg_q_r ? -dvd_r : dvd_r;
        end
    end

    // FSM state register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r <= S_IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // FSM next state and result-register load control.
    always_comb begin
        state_nxt_s = state_r;
        load_res_s  = 1'b0;
        res_nxt_s   = res_r;
        if (state_r == S_IDLE) begin
            if (accept_s) begin
                state_nxt_s = in_op[2] ? S_DSETUP : S_MUL;
            end else begin
                state_nxt_s = S_IDLE;
            end
        end else if (flush) begin
            state_nxt_s = S_IDLE;
        end else begin
            case (state_r)
                S_MUL: begin
                    if (cnt_r == CNT_W'(MUL_STAGES - 1)) begin
                        state_nxt_s = S_DONE;
                        load_res_s  = 1'b1;
                        res_nxt_s   = mul_res_s;
                    end else begin
                        state_nxt_s = S_MUL;
                    end
                end
                S_DSETUP: begin
`ifdef MDU_DIV_EARLY_OUT_EN
                    if (div0_s | ovf_s) begin
                        state_nxt_s = S_DONE;
                        load_res_s  = 1'b1;
                        res_nxt_s   = special_result(op_r[1], div0_s, a_r);
                    end else begin
                        state_nxt_s = S_DITER;
                    end
`else
                    state_nxt_s = S_DITER;
`endif
                end
                S_DITER: begin
                    if (cnt_r == CNT_W'(XLEN - 1)) begin
                        state_nxt_s = S_DFIX;
                    end else begin
                        state_nxt_s = S_DITER;
                    end
                end
                S_DFIX: begin
                    state_nxt_s = S_DONE;
                    load_res_s  = 1'b1;
                    res_nxt_s   = fix_res_s;
                end
                S_DONE:  state_nxt_s = S_IDLE;
                default: state_nxt_s = S_IDLE;
            endcase
        end
    end

    // Operand capture, counters, divider datapath and result registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            op_r          <= 3'd0;
            a_r           <= {XLEN{1'b0}};
            b_r           <= {XLEN{1'b0}};
            rd_r          <= {RD_W{1'b0}};
            cnt_r         <= {CNT_W{1'b0}};
            dvd_r         <= {XLEN{1'b0}};
            dvs_r         <= {XLEN{1'b0}};
            rem_r         <= {XLEN{1'b0}};
            div0_r        <= 1'b0;
            ovf_r         <= 1'b0;
            neg_q_r       <= 1'b0;
            neg_r_r       <= 1'b0;
            res_r         <= {XLEN{1'b0}};
            out_x_hold_r  <= {XLEN{1'b0}};
            out_rd_hold_r <= {RD_W{1'b0}};
        end else begin
            if (accept_s) begin
                op_r  <= in_op;
                a_r   <= in_x_rs1;
                b_r   <= in_x_rs2;
                rd_r  <= in_rd;
                cnt_r <= {CNT_W{1'b0}};
            end else begin
                case (state_r)
                    S_MUL: cnt_r <= cnt_r + CNT_W'(1);
                    S_DSETUP: begin
                        dvd_r   <= abs_a_s;
                        dvs_r   <= abs_b_s;
                        rem_r   <= {XLEN{1'b0}};
                        div0_r  <= div0_s;
                        ovf_r   <= ovf_s;
                        neg_q_r <= div_sgn_s & (a_r[XLEN-1] ^ b_r[XLEN-1]);
                        neg_r_r <= div_sgn_s & a_r[XLEN-1];
                        cnt_r   <= {CNT_W{1'b0}};
                    end
                    S_DITER: begin
                        rem_r <= q_bit_s ? diff_s[XLEN-1:0] : trial_s[XLEN-1:0];
                        dvd_r <= {dvd_r[XLEN-2:0], q_bit_s};
                        cnt_r <= cnt_r + CNT_W'(1);
                    end
                    default: cnt_r <= cnt_r;
                endcase
            end
            if (load_res_s) begin
                res_r <= res_nxt_s;
            end
            if (out_vld) begin
                out_x_hold_r  <= res_r;
                out_rd_hold_r <= rd_r;
            end
        end
    end

    // A flushed DONE cycle must neither strobe nor expose the new result.
    assign in_rdy   = (state_r == S_IDLE);
    assign busy     = (state_r != S_IDLE);
    assign out_vld  = (state_r == S_DONE) & ~flush;
    assign out_x_rd = out_vld ? res_r : out_x_hold_r;
    assign out_rd   = out_vld ? rd_r  : out_rd_hold_r;

endmodule

// File: tb/tb_ex_muldiv_unit.sv
module tb_ex_muldiv_unit;

    localparam int XLEN       = 32;
    localparam int MUL_STAGES = 2;
    localparam int RD_W       = 5;

    logic            clk = 1'b0;
    logic            rst;
    logic            in_vld;
    logic            in_rdy;
    logic [2:0]      in_op;
    logic [XLEN-1:0] in_x_rs1;
    logic [XLEN-1:0] in_x_rs2;
    logic [RD_W-1:0] in_rd;
    logic            flush;
    logic            busy;
    logic            out_vld;
    logic [RD_W-1:0] out_rd;
    logic [XLEN-1:0] out_x_rd;

    int n_checks = 0;
    int n_fail   = 0;
    logic [31:0] last_res = 32'd0;
    logic [4:0]  last_rd  = 5'd0;

    ex_muldiv_unit #(.XLEN(XLEN), .MUL_STAGES(MUL_STAGES), .RD_W(RD_W)) dut (
        .clk(clk), .rst(rst), .in_vld(in_vld), .in_rdy(in_rdy), .in_op(in_op),
        .in_x_rs1(in_x_rs1), .in_x_rs2(in_x_rs2), .in_rd(in_rd), .flush(flush),
        .busy(busy), .out_vld(out_vld), .out_rd(out_rd), .out_x_rd(out_x_rd)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Reference model straight from the RV32M arithmetic rules.
    function automatic logic [31:0] ref_result(input logic [2:0] op, input logic [31:0] a,
                                               input logic [31:0] b);
        longint     sa, sb, ub, ps;
        logic [63:0] pu;
        int         ia, ib;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        ub = longint'({32'd0, b});
        ia = $signed(a);
        ib = $signed(b);
        case (op)
            3'd0: begin ps = sa * sb; return ps[31:0]; end
            3'd1: begin ps = sa * sb; return ps[63:32]; end
            3'd2: begin ps = sa * ub; return ps[63:32]; end
            3'd3: begin pu = {32'd0, a} * {32'd0, b}; return pu[63:32]; end
            3'd4: begin
                if (b == 32'd0) return 32'hFFFF_FFFF;
                else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return a;
                else return 32'(ia / ib);
            end
            3'd5: begin
                if (b == 32'd0) return 32'hFFFF_FFFF;
                else return a / b;
            end
            3'd6: begin
                if (b == 32'd0) return a;
                else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'd0;
                else return 32'(ia % ib);
            end
            default: begin
                if (b == 32'd0) return a;
                else return a % b;
            end
        endcase
    endfunction

    function automatic int ref_latency(input logic [2:0] op, input logic [31:0] a,
                                       input logic [31:0] b);
        if (!op[2]) return MUL_STAGES + 1;
`ifdef MDU_DIV_EARLY_OUT_EN
        if (b == 32'd0) return 2;
        if (!op[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 2;
`endif
        return XLEN + 3;
    endfunction

    // Drive one request at a falling edge; returns after the accepting rising edge.
    task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                         input logic [4:0] rd);
        @(negedge clk);
        in_vld = 1'b1; in_op = op; in_x_rs1 = a; in_x_rs2 = b; in_rd = rd;
        @(posedge clk);
        #1;
        in_vld = 1'b0;
    endtask

    task automatic run_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                          input logic [4:0] rd, input string tag);
        logic [31:0] exp;
        int          lat;
        logic        seen;
        exp  = ref_result(op, a, b);
        @(negedge clk);
        check_val({tag, "_rdy"}, in_rdy, 1);
        issue(op, a, b, rd);
        lat  = 0;
        seen = 1'b0;
        while (!seen && lat < 100) begin
            @(negedge clk);
            lat++;
            if (out_vld) seen = 1'b1;
            else if (lat < ref_latency(op, a, b)) check_val({tag, "_busy"}, busy, 1);
        end
        check_val({tag, "_strobe"}, seen, 1);
        if (seen) begin
            check_val({tag, "_res"}, out_x_rd, exp);
            check_val({tag, "_rd"}, out_rd, rd);
            check_val({tag, "_lat"}, lat, ref_latency(op, a, b));
            check_val({tag, "_rdy_done"}, in_rdy, 0);
            @(negedge clk);
            check_val({tag, "_pulse"}, out_vld, 0);
            check_val({tag, "_hold"}, out_x_rd, exp);
            check_val({tag, "_idle"}, in_rdy, 1);
            last_res = exp;
            last_rd  = rd;
        end
    endtask

    task automatic expect_no_strobe(input string tag, input int cycles);
        int pulses;
        pulses = 0;
        for (int i = 0; i < cycles; i++) begin
            @(negedge clk);
            if (out_vld) pulses++;
        end
        check_val(tag, pulses, 0);
    endtask

    initial begin
        logic [2:0]  rop;
        logic [31:0] ra, rb;
        int          pick;

        rst = 1'b1; in_vld = 1'b0; in_op = 3'd0; in_x_rs1 = 32'd0; in_x_rs2 = 32'd0;
        in_rd = 5'd0; flush = 1'b0;
        repeat (3) @(negedge clk);
        check_val("rst_rdy", in_rdy, 1);
        check_val("rst_busy", busy, 0);
        check_val("rst_vld", out_vld, 0);
        check_val("rst_rd", out_rd, 0);
        check_val("rst_x", out_x_rd, 0);
        rst = 1'b0;

        // Directed cases.
        run_op(3'd1, 32'h8000_0000, 32'h8000_0000, 5'd1, "mulh_min");
        run_op(3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd2, "mulhsu_m1");
        run_op(3'd0, 32'd7, 32'hFFFF_FFFD, 5'd17, "mul_7x-3");
        run_op(3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd4, "mulhu_max");
        run_op(3'd4, 32'hFFFF_FFF9, 32'd2, 5'd5, "div_-7_2");
        run_op(3'd6, 32'hFFFF_FFF9, 32'd2, 5'd6, "rem_-7_2");
        run_op(3'd5, 32'd100, 32'd7, 5'd7, "divu_100_7");
        run_op(3'd4, 32'd5, 32'd0, 5'd8, "div_by0");
        run_op(3'd6, 32'd5, 32'd0, 5'd9, "rem_by0");
        run_op(3'd5, 32'd5, 32'd0, 5'd10, "divu_by0");
        run_op(3'd7, 32'd5, 32'd0, 5'd11, "remu_by0");
        run_op(3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 5'd12, "div_ovf");
        run_op(3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 5'd13, "rem_ovf");
        run_op(3'd5, 32'h8000_0000, 32'hFFFF_FFFF, 5'd14, "divu_big");
        run_op(3'd0, 32'd3, 32'd3, 5'd0, "mul_x0");

        // Flush in IDLE together with a request: must not be taken.
        @(negedge clk);
        in_vld = 1'b1; in_op = 3'd0; in_x_rs1 = 32'd9; in_x_rs2 = 32'd9; in_rd = 5'd3;
        flush = 1'b1;
        @(posedge clk);
        #1;
        in_vld = 1'b0; flush = 1'b0;
        @(negedge clk);
        check_val("flush_idle_busy", busy, 0);
        expect_no_strobe("flush_idle_nostrobe", 10);

        // Flush a DIVU at cycle 10.
        issue(3'd5, 32'd100, 32'd7, 5'd21);
        repeat (10) @(negedge clk);
        check_val("flush_mid_busy_before", busy, 1);
        flush = 1'b1;
        #1;
        check_val("flush_mid_vld", out_vld, 0);
        @(posedge clk);
        #1;
        flush = 1'b0;
        @(negedge clk);
        check_val("flush_mid_busy", busy, 0);
        check_val("flush_mid_rdy", in_rdy, 1);
        check_val("flush_mid_keep_x", out_x_rd, last_res);
        check_val("flush_mid_keep_rd", out_rd, last_rd);
        expect_no_strobe("flush_mid_nostrobe", 50);
        run_op(3'd0, 32'd6, 32'd7, 5'd22, "mul_after_flush");

        // Flush during the DONE cycle suppresses the strobe.
        issue(3'd0, 32'd11, 32'd13, 5'd23);
        repeat (MUL_STAGES + 1) @(negedge clk);
        check_val("flush_done_vld_pre", out_vld, 1);
        flush = 1'b1;
        #1;
        check_val("flush_done_vld", out_vld, 0);
        check_val("flush_done_keep_x", out_x_rd, last_res);
        @(posedge clk);
        #1;
        flush = 1'b0;
        @(negedge clk);
        check_val("flush_done_rdy", in_rdy, 1);
        check_val("flush_done_keep_x2", out_x_rd, last_res);
        expect_no_strobe("flush_done_nostrobe", 10);

        // Asynchronous reset in the middle of a divide.
        issue(3'd4, 32'hFFFF_FFF9, 32'd2, 5'd24);
        repeat (5) @(negedge clk);
        rst = 1'b1;
        #1;
        check_val("arst_busy", busy, 0);
        check_val("arst_rdy", in_rdy, 1);
        check_val("arst_vld", out_vld, 0);
        check_val("arst_x", out_x_rd, 0);
        check_val("arst_rd", out_rd, 0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        last_res = 32'd0;
        last_rd  = 5'd0;
        expect_no_strobe("arst_nostrobe", 45);

        // Randomized operations against the reference model.
        for (int n = 0; n < 60; n++) begin
            rop  = 3'($urandom_range(0, 7));
            ra   = $urandom;
            rb   = $urandom;
            pick = $urandom_range(0, 9);
            if (pick == 0) begin
                ra = 32'h8000_0000; rb = 32'hFFFF_FFFF;
            end else if (pick == 1) begin
                rb = 32'd0;
            end else if (pick == 2) begin
                rb = 32'($urandom_range(1, 20));
            end else if (pick == 3) begin
                ra = 32'($urandom_range(0, 50)) - 32'd25;
                rb = 32'($urandom_range(0, 10)) - 32'd5;
            end
            run_op(rop, ra, rb, 5'($urandom_range(0, 31)), $sformatf("rnd%0d_op%0d", n, rop));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
